// File: rtl/bus_arbiter_rr_if.sv
// bus_arbiter_rr_if: request/grant bundle between the bus masters and bus_arbiter_rr.
// master->arbiter: req, free, req_words; arbiter->master: grant, grant_id, busy,
// word_number, timeout_err.
interface bus_arbiter_rr_if #(
   parameter int NUM_MASTERS = 4,
   parameter int WN_WIDTH    = 8
);
   localparam int IDW = $clog2(NUM_MASTERS);

   logic [NUM_MASTERS-1:0]          req;
   logic [NUM_MASTERS-1:0]          free;
   logic [NUM_MASTERS*WN_WIDTH-1:0] req_words;
   logic [NUM_MASTERS-1:0]          grant;
   logic [IDW-1:0]                  grant_id;
   logic                            busy;
   logic [WN_WIDTH-1:0]             word_number;
   logic                            timeout_err;

   modport master (
      output req, free, req_words,
      input  grant, grant_id, busy,
      input  word_number, timeout_err
   );

   modport slave (
      input  req, free, req_words,
      output grant, grant_id, busy,
      output word_number, timeout_err
   );
endinterface

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: N-master bus arbiter, fixed priority or round-robin, grant held
// until the owner pulses free; latches the owner's word count at grant.
// Ports: clk, resetn (sync, active-low), bus (bus_arbiter_rr_if.slave).
// Optional macro BUS_ARB_TIMEOUT_EN adds a watchdog that force-releases the bus.
module bus_arbiter_rr #(
   parameter int NUM_MASTERS    = 4,
   parameter int WN_WIDTH       = 8,
   parameter int RR_MODE        = 1,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic            clk,
   input  logic            resetn,
   bus_arbiter_rr_if.slave bus
);
   localparam int IDW = $clog2(NUM_MASTERS);

   typedef enum logic {IDLE, BUSY} state_e;

   state_e                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [IDW-1:0]         gid_q, gid_d;
   logic [IDW-1:0]         ptr_q, ptr_d;
   logic [WN_WIDTH-1:0]    wn_q, wn_d;
   logic                   tmo_q, tmo_d;
   logic [IDW-1:0]         win;
   logic                   found;
   logic                   wd_hit;

   logic [NUM_MASTERS-1:0][WN_WIDTH-1:0] words;
   assign words = bus.req_words;

   // Winner search; in RR mode the scan starts at ptr_q and wraps
   // explicitly so non-power-of-2 master counts work.
   always_comb begin : pick
      logic [IDW:0]   sum;
      logic [IDW-1:0] idx;
      found = 1'b0;
      win   = '0;
      sum   = '0;
      idx   = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (RR_MODE != 0) begin
            sum = {1'b0, ptr_q} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(NUM_MASTERS))
               sum = sum - (IDW+1)'(NUM_MASTERS);
            idx = sum[IDW-1:0];
         end else begin
            idx = IDW'(i);
         end
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin : nxt
      state_d = state_q;
      grant_d = grant_q;
      gid_d   = gid_q;
      ptr_d   = ptr_q;
      wn_d    = wn_q;
      tmo_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d = BUSY;
               grant_d = NUM_MASTERS'(1) << win;
               gid_d   = win;
               wn_d    = words[win];
               ptr_d   = (win == IDW'(NUM_MASTERS-1)) ?
                         '0 : win + IDW'(1);
            end
         end
         BUSY: begin
            // free wins over a watchdog expiry on the same cycle
            if (bus.free[gid_q]) begin
               state_d = IDLE;
               grant_d = '0;
            end else if (wd_hit) begin
               state_d = IDLE;
               grant_d = '0;
               tmo_d   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         grant_q <= '0;
         gid_q   <= '0;
         ptr_q   <= '0;
         wn_q    <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gid_q   <= gid_d;
         ptr_q   <= ptr_d;
         wn_q    <= wn_d;
         tmo_q   <= tmo_d;
      end
   end

`ifdef BUS_ARB_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

   logic [WDW-1:0] wd_q, wd_d;

   // Held at zero while idle, so it starts from 0 on every grant.
   always_comb begin
      wd_d = wd_q;
      if (state_q == IDLE) wd_d = '0;
      else                 wd_d = wd_q + WDW'(1);
   end

   always_ff @(posedge clk) begin
      if (!resetn) wd_q <= '0;
      else         wd_q <= wd_d;
   end

   assign wd_hit = (state_q == BUSY) &&
                   (wd_q == WDW'(TIMEOUT_CYCLES - 1));
`else
   // Timeout length only matters when the watchdog is built in.
   localparam int unused_timeout = TIMEOUT_CYCLES;
   assign wd_hit = 1'b0;
`endif

   assign bus.grant       = grant_q;
   assign bus.grant_id    = gid_q;
   assign bus.busy        = (state_q == BUSY);
   assign bus.word_number = wn_q;
   assign bus.timeout_err = tmo_q;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: self-checking bench for bus_arbiter_rr, one fixed-priority
// and one round-robin instance; expected owners queued and popped at grant.
module tb_bus_arbiter_rr;
   localparam int N = 4;
   localparam int W = 8;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   bus_arbiter_rr_if #(.NUM_MASTERS(N), .WN_WIDTH(W)) f_if ();
   bus_arbiter_rr_if #(.NUM_MASTERS(N), .WN_WIDTH(W)) r_if ();

   bus_arbiter_rr #(
      .NUM_MASTERS(N), .WN_WIDTH(W),
      .RR_MODE(0), .TIMEOUT_CYCLES(8)
   ) u_fix (
      .clk(clk), .resetn(resetn), .bus(f_if)
   );

   bus_arbiter_rr #(
      .NUM_MASTERS(N), .WN_WIDTH(W),
      .RR_MODE(1), .TIMEOUT_CYCLES(8)
   ) u_rr (
      .clk(clk), .resetn(resetn), .bus(r_if)
   );

   int total = 0;
   int bad   = 0;
   int exp_q[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      f_if.req = 4'b1111;
      r_if.req = 4'b1111;
      f_if.free = '0;
      r_if.free = '0;
      f_if.req_words = {8'd13, 8'd12, 8'd16, 8'd10};
      r_if.req_words = {8'd13, 8'd12, 8'd16, 8'd10};
      repeat (2) tick();
      total++;
      if (f_if.grant !== 4'b0) begin
         bad++;
         $display("FAIL rst_f_grant got=%b want=0000", f_if.grant);
      end
      total++;
      if (r_if.grant !== 4'b0) begin
         bad++;
         $display("FAIL rst_r_grant got=%b want=0000", r_if.grant);
      end
      total++;
      if (f_if.busy !== 1'b0 || r_if.busy !== 1'b0) begin
         bad++;
         $display("FAIL rst_busy got=%b%b want=00",
                  f_if.busy, r_if.busy);
      end
      total++;
      if (f_if.word_number !== 8'd0 || r_if.word_number !== 8'd0) begin
         bad++;
         $display("FAIL rst_wn got=%0d/%0d want=0",
                  f_if.word_number, r_if.word_number);
      end
      total++;
      if (f_if.timeout_err !== 1'b0 || f_if.grant_id !== 2'd0) begin
         bad++;
         $display("FAIL rst_tmo_gid got=%b/%0d want=0/0",
                  f_if.timeout_err, f_if.grant_id);
      end
      resetn = 1'b1;
      f_if.req = '0;
      r_if.req = '0;
      tick();
      total++;
      if (f_if.grant !== 4'b0 || r_if.grant !== 4'b0) begin
         bad++;
         $display("FAIL idle_grant got=%b/%b want=0000",
                  f_if.grant, r_if.grant);
      end
   endtask

   task automatic test_fixed();
      int e;
      logic [3:0] eg;
      exp_q.push_back(1);
      f_if.req = 4'b0110;
      tick();
      e = exp_q.pop_front();
      eg = 4'b0001 << e;
      total++;
      if (f_if.grant !== eg || f_if.grant_id !== 2'(e)) begin
         bad++;
         $display("FAIL fix_grant got=%b/%0d want=%b/%0d",
                  f_if.grant, f_if.grant_id, eg, e);
      end
      total++;
      if (f_if.word_number !== 8'd16 || f_if.busy !== 1'b1) begin
         bad++;
         $display("FAIL fix_wn got=%0d/%b want=16/1",
                  f_if.word_number, f_if.busy);
      end
      f_if.free = 4'b0010;
      f_if.req = 4'b0100;
      tick();
      f_if.free = '0;
      total++;
      if (f_if.grant !== 4'b0 || f_if.busy !== 1'b0) begin
         bad++;
         $display("FAIL fix_release got=%b/%b want=0000/0",
                  f_if.grant, f_if.busy);
      end
      total++;
      if (f_if.grant_id !== 2'd1 || f_if.word_number !== 8'd16) begin
         bad++;
         $display("FAIL fix_hold_id got=%0d/%0d want=1/16",
                  f_if.grant_id, f_if.word_number);
      end
      exp_q.push_back(2);
      tick();
      e = exp_q.pop_front();
      eg = 4'b0001 << e;
      total++;
      if (f_if.grant !== eg || f_if.word_number !== 8'd12) begin
         bad++;
         $display("FAIL fix_next got=%b/%0d want=%b/12",
                  f_if.grant, f_if.word_number, eg);
      end
      f_if.free = 4'b0100;
      f_if.req = 4'b1011;
      tick();
      f_if.free = '0;
      exp_q.push_back(0);
      tick();
      e = exp_q.pop_front();
      eg = 4'b0001 << e;
      total++;
      if (f_if.grant !== eg || f_if.word_number !== 8'd10) begin
         bad++;
         $display("FAIL fix_prio got=%b/%0d want=%b/10",
                  f_if.grant, f_if.word_number, eg);
      end
      f_if.free = 4'b0001;
      f_if.req = '0;
      tick();
      f_if.free = '0;
      total++;
      if (f_if.grant !== 4'b0) begin
         bad++;
         $display("FAIL fix_end got=%b want=0000", f_if.grant);
      end
   endtask

   task automatic test_rr();
      int e;
      logic [3:0] eg;
      r_if.req = 4'b1111;
      for (int k = 0; k < 5; k++) exp_q.push_back(k % N);
      for (int k = 0; k < 5; k++) begin
         tick();
         e = exp_q.pop_front();
         eg = 4'b0001 << e;
         total++;
         if (r_if.grant !== eg || r_if.grant_id !== 2'(e)) begin
            bad++;
            $display("FAIL rr_order k=%0d got=%b/%0d want=%b/%0d",
                     k, r_if.grant, r_if.grant_id, eg, e);
         end
         repeat (2) tick();
         total++;
         if (r_if.grant !== eg) begin
            bad++;
            $display("FAIL rr_hold k=%0d got=%b want=%b",
                     k, r_if.grant, eg);
         end
         r_if.free = eg;
         tick();
         r_if.free = '0;
         total++;
         if (r_if.grant !== 4'b0 || r_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL rr_dead k=%0d got=%b/%b want=0000/0",
                     k, r_if.grant, r_if.busy);
         end
      end
      r_if.req = '0;
   endtask

   task automatic test_hold();
      int e;
      logic [3:0] eg;
      exp_q.push_back(2);
      r_if.req = 4'b0100;
      tick();
      e = exp_q.pop_front();
      eg = 4'b0001 << e;
      total++;
      if (r_if.grant !== eg) begin
         bad++;
         $display("FAIL hold_start got=%b want=%b", r_if.grant, eg);
      end
      r_if.req = '0;
      r_if.free = 4'b1001;
      tick();
      r_if.free = '0;
      total++;
      if (r_if.grant !== 4'b0100) begin
         bad++;
         $display("FAIL hold_foreign got=%b want=0100", r_if.grant);
      end
      repeat (3) tick();
      total++;
      if (r_if.grant !== 4'b0100 || r_if.busy !== 1'b1) begin
         bad++;
         $display("FAIL hold_noreq got=%b/%b want=0100/1",
                  r_if.grant, r_if.busy);
      end
      r_if.free = 4'b0100;
      r_if.req = 4'b0010;
      tick();
      r_if.free = '0;
      total++;
      if (r_if.grant !== 4'b0) begin
         bad++;
         $display("FAIL same_cycle got=%b want=0000", r_if.grant);
      end
      exp_q.push_back(1);
      tick();
      e = exp_q.pop_front();
      eg = 4'b0001 << e;
      total++;
      if (r_if.grant !== eg || r_if.word_number !== 8'd16) begin
         bad++;
         $display("FAIL after_dead got=%b/%0d want=%b/16",
                  r_if.grant, r_if.word_number, eg);
      end
      r_if.free = 4'b0010;
      r_if.req = '0;
      tick();
      r_if.free = '0;
   endtask

   task automatic test_reset_busy();
      int e;
      logic [3:0] eg;
      exp_q.push_back(3);
      r_if.req = 4'b1000;
      tick();
      e = exp_q.pop_front();
      eg = 4'b0001 << e;
      total++;
      if (r_if.grant !== eg || r_if.busy !== 1'b1) begin
         bad++;
         $display("FAIL rb_owner got=%b/%b want=%b/1",
                  r_if.grant, r_if.busy, eg);
      end
      resetn = 1'b0;
      r_if.req = 4'b1010;
      tick();
      total++;
      if (r_if.grant !== 4'b0 || r_if.busy !== 1'b0 ||
          r_if.word_number !== 8'd0) begin
         bad++;
         $display("FAIL rb_drop got=%b/%b/%0d want=0000/0/0",
                  r_if.grant, r_if.busy, r_if.word_number);
      end
      resetn = 1'b1;
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(1);
         tick();
         e = exp_q.pop_front();
         eg = 4'b0001 << e;
         total++;
         if (r_if.grant !== eg) begin
            bad++;
            $display("FAIL rb_first k=%0d got=%b want=%b",
                     k, r_if.grant, eg);
         end
         if (k == 0) begin
            resetn = 1'b0;
            tick();
            resetn = 1'b1;
         end
      end
      r_if.free = 4'b0010;
      r_if.req = '0;
      tick();
      r_if.free = '0;
      total++;
      if (r_if.grant !== 4'b0) begin
         bad++;
         $display("FAIL rb_end got=%b want=0000", r_if.grant);
      end
   endtask

   task automatic test_timeout();
      int e;
      logic [3:0] eg;
      exp_q.push_back(1);
      f_if.req = 4'b0010;
      tick();
      e = exp_q.pop_front();
      eg = 4'b0001 << e;
      total++;
      if (f_if.grant !== eg) begin
         bad++;
         $display("FAIL to_grant got=%b want=%b", f_if.grant, eg);
      end
      f_if.req = '0;
`ifdef BUS_ARB_TIMEOUT_EN
      for (int k = 1; k < 8; k++) begin
         tick();
         total++;
         if (f_if.grant !== eg || f_if.timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL to_hold k=%0d got=%b/%b want=%b/0",
                     k, f_if.grant, f_if.timeout_err, eg);
         end
      end
      tick();
      total++;
      if (f_if.grant !== 4'b0 || f_if.busy !== 1'b0 ||
          f_if.timeout_err !== 1'b1) begin
         bad++;
         $display("FAIL to_fire got=%b/%b/%b want=0000/0/1",
                  f_if.grant, f_if.busy, f_if.timeout_err);
      end
      tick();
      total++;
      if (f_if.timeout_err !== 1'b0) begin
         bad++;
         $display("FAIL to_pulse got=%b want=0", f_if.timeout_err);
      end
`else
      for (int k = 0; k < 100; k++) begin
         tick();
         total++;
         if (f_if.grant !== eg || f_if.timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL nowd_hold k=%0d got=%b/%b want=%b/0",
                     k, f_if.grant, f_if.timeout_err, eg);
         end
      end
      f_if.free = 4'b0010;
      tick();
      f_if.free = '0;
      total++;
      if (f_if.grant !== 4'b0 || f_if.timeout_err !== 1'b0) begin
         bad++;
         $display("FAIL nowd_free got=%b/%b want=0000/0",
                  f_if.grant, f_if.timeout_err);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_fixed();
      test_rr();
      test_hold();
      test_reset_busy();
      test_timeout();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL sb_left got=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
